ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/exmem_pkg.sv | 24 ++
 rtl/exmem_skid.sv | 84 ++++++++
 rtl/ex_mem_stage.sv | 101 ++++++++++
 tb/tb_ex_mem_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exmem_pkg.sv
// Shared opcode constants and the packed control part of an EX/MEM pipeline entry.
package exmem_pkg;

  localparam logic [4:0] ALU_DIV = 5'b00011;
  localparam logic [4:0] ALU_MOD = 5'b00100;
  localparam logic [4:0] ALU_CMP = 5'b00101;
  localparam logic [4:0] ALU_NOP = 5'b01101;

  // Control fields of a buffered entry; the DW-wide data fields are added by the stage.
  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic       wb_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       exc;
  } exmem_ctrl_t;

  // Opcodes that never write back or touch memory.
  function automatic logic is_no_side_effect_op(input logic [4:0] op);
    return (op == ALU_NOP) || (op == ALU_CMP);
  endfunction

endpackage

// File: rtl/exmem_skid.sv
// Entry buffer between execute and memory: 2-entry FIFO with registered ready when
// EXMEM_SKID_EN is defined, otherwise a single pass-through pipeline register.
module exmem_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic push;
  logic pop;

  assign push = push_valid && push_ready && !flush;
  assign pop  = pop_valid && pop_ready && !flush;

`ifdef EXMEM_SKID_EN
  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;

  // Ready depends only on stored occupancy, so out_ready never reaches in_ready.
  assign push_ready = (cnt != 2'd2);
  assign pop_valid  = (cnt != 2'd0);
  assign pop_data   = mem[rd_ptr];
  assign count      = cnt;

  // NOTE: storage is reset as well because the head slot drives the outputs directly,
  // and those must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  logic [W-1:0] mem;
  logic         full;

  assign push_ready = !full || pop_ready;
  assign pop_valid  = full;
  assign pop_data   = mem;
  assign count      = {1'b0, full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      mem  <= push_data;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: masks controls for nop/cmp/exception ops, tracks the flags
// register and buffers entries in exmem_skid. Define EXMEM_SKID_EN for the 2-entry skid buffer.
module ex_mem_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_aluresult,
  input  logic [1:0]    in_flags,
  input  logic [4:0]    in_alusignal,
  input  logic [4:0]    in_rd,
  input  logic          in_wb_en,
  input  logic          in_mem_rd,
  input  logic          in_mem_wr,
  input  logic [DW-1:0] in_store_data,
  input  logic          in_divz,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_aluresult,
  output logic [4:0]    out_rd,
  output logic          out_wb_en,
  output logic          out_mem_rd,
  output logic          out_mem_wr,
  output logic [DW-1:0] out_store_data,
  output logic [4:0]    out_opcode,
  output logic          out_exc,
  output logic [1:0]    out_flags,
  output logic [1:0]    out_count
);

  import exmem_pkg::*;

  typedef struct packed {
    logic [DW-1:0] aluresult;
    logic [DW-1:0] store_data;
    exmem_ctrl_t   ctrl;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t     in_entry;
  entry_t     head;
  logic       exc;
  logic       squash;
  logic       accept;
  logic [1:0] flags_q;

  assign exc    = in_divz && ((in_alusignal == ALU_DIV) || (in_alusignal == ALU_MOD));
  assign squash = exc || is_no_side_effect_op(in_alusignal);
  assign accept = in_valid && in_ready && !flush;

  // NOTE: the whole struct gets a default first so no field can hold state and infer a latch.
  always_comb begin
    in_entry             = '0;
    in_entry.aluresult   = in_aluresult;
    in_entry.store_data  = in_store_data;
    in_entry.ctrl.opcode = in_alusignal;
    in_entry.ctrl.rd     = in_rd;
    in_entry.ctrl.wb_en  = in_wb_en && !squash;
    in_entry.ctrl.mem_rd = in_mem_rd && !squash;
    in_entry.ctrl.mem_wr = in_mem_wr && !squash;
    in_entry.ctrl.exc    = exc;
  end

  exmem_skid #(.W(EW)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head),
    .count      (out_count)
  );

  // NOTE: sequential state uses non-blocking assignment so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 2'b00;
    end else if (accept && (in_alusignal == ALU_CMP)) begin
      flags_q <= in_flags;
    end
  end

  assign out_flags      = flags_q;
  assign out_aluresult  = head.aluresult;
  assign out_store_data = head.store_data;
  assign out_opcode     = head.ctrl.opcode;
  assign out_rd         = head.ctrl.rd;
  assign out_wb_en      = head.ctrl.wb_en;
  assign out_mem_rd     = head.ctrl.mem_rd;
  assign out_mem_wr     = head.ctrl.mem_wr;
  assign out_exc        = head.ctrl.exc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed steps plus randomized traffic
// compared against a queue-based reference model.
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;
  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_MOV = 5'b01000;
  localparam logic [4:0] OP_NOP = 5'b01101;
`ifdef EXMEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_aluresult;
  logic [1:0]    in_flags;
  logic [4:0]    in_alusignal;
  logic [4:0]    in_rd;
  logic          in_wb_en;
  logic          in_mem_rd;
  logic          in_mem_wr;
  logic [DW-1:0] in_store_data;
  logic          in_divz;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_aluresult;
  logic [4:0]    out_rd;
  logic          out_wb_en;
  logic          out_mem_rd;
  logic          out_mem_wr;
  logic [DW-1:0] out_store_data;
  logic [4:0]    out_opcode;
  logic          out_exc;
  logic [1:0]    out_flags;
  logic [1:0]    out_count;

  ex_mem_stage #(.DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_aluresult   (in_aluresult),
    .in_flags       (in_flags),
    .in_alusignal   (in_alusignal),
    .in_rd          (in_rd),
    .in_wb_en       (in_wb_en),
    .in_mem_rd      (in_mem_rd),
    .in_mem_wr      (in_mem_wr),
    .in_store_data  (in_store_data),
    .in_divz        (in_divz),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_aluresult  (out_aluresult),
    .out_rd         (out_rd),
    .out_wb_en      (out_wb_en),
    .out_mem_rd     (out_mem_rd),
    .out_mem_wr     (out_mem_wr),
    .out_store_data (out_store_data),
    .out_opcode     (out_opcode),
    .out_exc        (out_exc),
    .out_flags      (out_flags),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [DW-1:0] sd;
    logic [4:0]    rd;
    logic [4:0]    op;
    logic          wb;
    logic          mrd;
    logic          mwr;
    logic          exc;
  } exp_t;

  exp_t       q[$];
  logic [1:0] m_flags;
  int         compared   = 0;
  int         mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] op, input logic [DW-1:0] res,
                       input logic [4:0] rd, input bit wb, input bit mrd, input bit mwr,
                       input logic [1:0] fl, input bit dz, input logic [DW-1:0] sd);
    in_valid      = v;
    in_alusignal  = op;
    in_aluresult  = res;
    in_rd         = rd;
    in_wb_en      = wb;
    in_mem_rd     = mrd;
    in_mem_wr     = mwr;
    in_flags      = fl;
    in_divz       = dz;
    in_store_data = sd;
  endtask

  task automatic idle();
    drive(1'b0, OP_ADD, '0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0);
  endtask

  // One clock: compare DUT against the model, then advance the model across the edge.
  task automatic cycle();
    exp_t e;
    bit   exp_rdy;
    bit   acc;
    bit   pop;
    bit   killed;
    #1;
    exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
    check("in_ready",  64'(in_ready),  64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("out_count", 64'(out_count), 64'(q.size()));
    check("out_flags", 64'(out_flags), 64'(m_flags));
    if (q.size() > 0) begin
      e = q[0];
      check("head_result", 64'(out_aluresult),  64'(e.res));
      check("head_store",  64'(out_store_data), 64'(e.sd));
      check("head_rd",     64'(out_rd),         64'(e.rd));
      check("head_opcode", 64'(out_opcode),     64'(e.op));
      check("head_wb_en",  64'(out_wb_en),      64'(e.wb));
      check("head_mem_rd", 64'(out_mem_rd),     64'(e.mrd));
      check("head_mem_wr", 64'(out_mem_wr),     64'(e.mwr));
      check("head_exc",    64'(out_exc),        64'(e.exc));
    end
    acc = in_valid && exp_rdy && !flush;
    pop = (q.size() > 0) && out_ready && !flush;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.res  = in_aluresult;
        e.sd   = in_store_data;
        e.rd   = in_rd;
        e.op   = in_alusignal;
        e.exc  = in_divz && (in_alusignal == OP_DIV || in_alusignal == OP_MOD);
        killed = e.exc || in_alusignal == OP_NOP || in_alusignal == OP_CMP;
        e.wb   = in_wb_en && !killed;
        e.mrd  = in_mem_rd && !killed;
        e.mwr  = in_mem_wr && !killed;
        q.push_back(e);
        if (in_alusignal == OP_CMP) m_flags = in_flags;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] ops [7];
    ops = '{OP_ADD, 5'b00001, OP_DIV, OP_MOD, OP_CMP, OP_NOP, OP_MOV};
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    m_flags   = 2'b00;
    idle();

    // Outputs cleared while in reset.
    #12;
    check("rst_out_valid", 64'(out_valid),      64'd0);
    check("rst_out_count", 64'(out_count),      64'd0);
    check("rst_out_flags", 64'(out_flags),      64'd0);
    check("rst_out_exc",   64'(out_exc),        64'd0);
    check("rst_result",    64'(out_aluresult),  64'd0);
    check("rst_store",     64'(out_store_data), 64'd0);
    check("rst_rd",        64'(out_rd),         64'd0);
    check("rst_wb_en",     64'(out_wb_en),      64'd0);
    check("rst_mem_rd",    64'(out_mem_rd),     64'd0);
    check("rst_mem_wr",    64'(out_mem_wr),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add: visible one cycle after acceptance.
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'hA5A5_0001);
    cycle();
    idle();
    #1;
    check("add_valid",  64'(out_valid),     64'd1);
    check("add_result", 64'(out_aluresult), 64'd5);
    check("add_rd",     64'(out_rd),        64'd3);
    check("add_wb_en",  64'(out_wb_en),     64'd1);
    cycle();

    // cmp updates flags and loses wb_en; a following mov leaves flags alone.
    drive(1'b1, OP_CMP, 32'h1234, 5'd7, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, '0);
    cycle();
    drive(1'b1, OP_MOV, 32'h55, 5'd8, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, '0);
    #1;
    check("cmp_flags", 64'(out_flags), 64'b10);
    check("cmp_wb_en", 64'(out_wb_en), 64'd0);
    cycle();
    idle();
    #1;
    check("mov_flags", 64'(out_flags), 64'b10);
    cycle();

    // Divide-by-zero exception versus divz on a non-divide op.
    drive(1'b1, OP_DIV, 32'h9, 5'd4, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, '0);
    cycle();
    drive(1'b1, OP_ADD, 32'hA, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, '0);
    #1;
    check("div_exc",   64'(out_exc),   64'd1);
    check("div_wb_en", 64'(out_wb_en), 64'd0);
    cycle();
    idle();
    #1;
    check("add_divz_exc",   64'(out_exc),   64'd0);
    check("add_divz_wb_en", 64'(out_wb_en), 64'd1);
    cycle();
    cycle();

    // Backpressure: fill to capacity, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'hAAAA, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    cycle();
    drive(1'b1, OP_ADD, 32'hBBBB, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    if (SKID) begin
      cycle();
      drive(1'b1, OP_ADD, 32'hCCCC, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    end
    #1;
    check("full_in_ready", 64'(in_ready),      64'd0);
    check("full_count",    64'(out_count),     SKID ? 64'd2 : 64'd1);
    check("full_head",     64'(out_aluresult), 64'hAAAA);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 1) idle();
    end
    idle();
    cycle();

    // Flush at full occupancy with a cmp presented: everything dropped, flags kept.
    out_ready = 1'b0;
    drive(1'b1, OP_MOV, 32'h11, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    cycle();
    if (SKID) cycle();
    flush = 1'b1;
    drive(1'b1, OP_CMP, 32'h22, 5'd9, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, '0);
    cycle();
    flush = 1'b0;
    idle();
    #1;
    check("flush_count", 64'(out_count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_flags", 64'(out_flags), 64'b10);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), ops[$urandom_range(0, 6)], $urandom(),
            5'($urandom_range(0, 31)), 1'($urandom()), 1'($urandom()), 1'($urandom()),
            2'($urandom()), ($urandom_range(0, 3) == 0), $urandom());
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush     = 1'b0;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Reset dropped mid-stream with one entry held.
    out_ready = 1'b0;
    drive(1'b1, OP_CMP, 32'h77, 5'd6, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, '0);
    cycle();
    idle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_flags", 64'(out_flags), 64'd0);
    check("async_rst_count", 64'(out_count), 64'd0);
    q.delete();
    m_flags = 2'b00;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'hFACE, 5'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0BAD);
    cycle();
    idle();
    #1;
    check("post_rst_valid",  64'(out_valid),     64'd1);
    check("post_rst_result", 64'(out_aluresult), 64'hFACE);
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
